// File: rtl/imem_boot_loader.sv
// Boot loader: receives a little-endian 16-bit word count and then the
// instruction words as a byte stream, writes them into instruction memory and releases the core.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [15:0]           count_q, count_d;
  logic [23:0]           partial_q, partial_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;

  logic        accept;
  logic [15:0] n_len;

  assign accept = in_valid & in_ready_q;
  assign n_len  = {in_data, count_q[7:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    count_d      = count_q;
    partial_d    = partial_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      LEN0: begin
        if (accept) begin
          count_d[7:0] = in_data;
          state_d      = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          count_d = n_len;
          if (n_len == 16'd0)             state_d = DONE;
          else if (int'(n_len) > DEPTH)   state_d = ERR;
          else                            state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: partial_d[7:0]   = in_data;
            2'd1: partial_d[15:8]  = in_data;
            2'd2: partial_d[23:16] = in_data;
            2'd3: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
              imem_wdata_d = {in_data, partial_q};
              word_cnt_d   = word_cnt_q + 16'd1;
              if (word_cnt_q == count_q - 16'd1) state_d = DONE;
            end
          endcase
        end
      end
      DONE: begin
        if (reload) begin
          state_d    = LEN0;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          count_d    = 16'd0;
          partial_d  = 24'd0;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = LEN0;
    endcase

    // Ready is registered, so it is derived from where the FSM lands next.
    in_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LEN0;
      in_ready_q   <= 1'b0;
      byte_cnt_q   <= 2'd0;
      word_cnt_q   <= 16'd0;
      count_q      <= 16'd0;
      partial_q    <= 24'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      count_q      <= count_d;
      partial_q    <= partial_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  // Core reset drops together with the final write because both come from the same edge.
  assign core_rst   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have one parameter: ADDR_WIDTH, default 8, the instruction-memory word-address width (DEPTH = 2**ADDR_WIDTH words).
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte-stream source has a byte on in_data.
- in_data  input  8  boot byte.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle request to restart loading from state DONE.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  instruction-memory word address.
- imem_wdata  output  32  instruction word.
- core_rst  output  1  reset to the processor core, active-high.
- done  output  1  load finished successfully.
- error  output  1  declared word count exceeds DEPTH.

Function
REQ-003 A byte SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-004 The FSM SHALL have states LEN0, LEN1, DATA, DONE and ERR.
REQ-005 in_ready SHALL be a registered output: 1 in LEN0, LEN1 and DATA, and 0 in DONE and ERR.
REQ-006 In LEN0, an accepted byte SHALL become count[7:0] and the FSM SHALL go to LEN1.
REQ-007 In LEN1, an accepted byte SHALL become count[15:8], forming the 16-bit word count N.
REQ-008 On leaving LEN1, the next state SHALL be chosen as follows:
- N = 0: DONE.
- N > DEPTH: ERR.
- otherwise: DATA.
REQ-009 In DATA, bytes SHALL be assembled little-endian: the first byte goes to bits 7:0 and the fourth byte goes to bits 31:24.
REQ-010 A 2-bit byte counter SHALL wrap 3->0 on each completed word.
REQ-011 On the edge that accepts the fourth byte of word k (k from 0), the block SHALL register imem_we=1, imem_addr=k and imem_wdata=the assembled word, so the write is visible exactly one cycle after that acceptance.
REQ-012 imem_we SHALL be high for exactly one cycle per word.
REQ-013 imem_addr and imem_wdata SHALL hold their last values while imem_we=0.
REQ-014 in_ready SHALL stay 1 during a write cycle; bytes of word k+1 MAY be accepted in the same cycle imem_we is high for word k.
REQ-015 The word counter SHALL be 16 bits wide.
REQ-016 The FSM SHALL enter DONE on the edge that accepts the fourth byte of word N-1.
REQ-017 In DONE, done SHALL be 1.
REQ-018 core_rst SHALL deassert on the same edge that entry to DONE becomes visible, i.e. in the same cycle as the final imem_we, so the core's first fetch follows the final write.
REQ-019 In ERR, error SHALL be 1 and core_rst SHALL remain 1; only rst exits ERR.
REQ-020 In DONE, reload=1 SHALL, on the next edge:
- move the FSM to LEN0;
- set in_ready=1, core_rst=1 and done=0;
- clear the byte counter, word counter and count.
REQ-021 reload SHALL be ignored in every state other than DONE.
REQ-022 Gaps (in_valid=0) of any length SHALL be tolerated in any accepting state with no change of state, counters or partial word.
REQ-023 Bytes presented while in_ready=0 SHALL be dropped and SHALL cause no state change.

Reset
REQ-024 While rst=1, and immediately on its assertion, the block SHALL set:
- state=LEN0, with byte counter, word counter, count and partial word all 0;
- in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0;
- core_rst=1, done=0, error=0.
REQ-025 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-026 rst asserted mid-load SHALL abort the load: no further imem_we, and the partial word is discarded.

Verification
REQ-027 Normal load, 2 words. Stimulus: bytes 02 00 | 13 05 50 00 | 93 05 A0 00, in_valid continuous. Required response:
- imem_we pulses at addr 0 with 0x00500513, then at addr 1 with 0x00A00593;
- done=1 and core_rst=0 in the same cycle as the second write;
- in_ready=0 afterwards.
REQ-028 Zero count. Stimulus: bytes 00 00. Required response: DONE one cycle after the second byte is accepted, with no imem_we and core_rst=0.
REQ-029 Overflow, ADDR_WIDTH=8. Stimulus: bytes 01 01 (N=257). Required response: error=1, in_ready=0, core_rst=1, with no writes; N=256 loads normally and its final write goes to addr 255.
REQ-030 Stalls. Stimulus: the normal-load case with random in_valid gaps. Required response: written addresses and data identical to the normal-load case, one imem_we per word.
REQ-031 Reset mid-word. Stimulus: rst asserted after bytes 01 00 13 05, then a fresh stream 01 00 EF BE AD DE. Required response: one write, addr 0 with data 0xDEADBEEF.
REQ-032 Reload. Stimulus: reload=1 in DONE, then bytes 01 00 78 56 34 12. Required response:
- core_rst=1 while loading;
- a single write, addr 0 with data 0x12345678;
- done=1 again;
- reload asserted during DATA has no effect.
